aes_round_sched: RTL and testbench

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

---
 rtl/aes_sched_pkg.sv | 20 ++
 rtl/aes_rcon_gen.sv | 26 ++
 rtl/aes_round_sched.sv | 146 ++++++++++++++
 tb/tb_aes_round_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES-128 round scheduler.
package aes_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPrekey,
        StIssue,
        StWait,
        StOut
    } sched_state_e;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam logic [7:0]  RCON_INIT  = 8'h01;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// AES key-expansion round-constant sequencer: load to RCON_INIT, step by xtime.
module aes_rcon_gen
    import aes_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [7:0] rcon
);

    logic [7:0] rcon_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcon_q <= 8'h00;
        end else if (load) begin
            rcon_q <= RCON_INIT;
        end else if (step) begin
            rcon_q <= xtime(rcon_q);
        end
    end

    assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_sched.sv
// AES-128 round scheduler driving an external shared round datapath and key-expansion unit.
// Optional block counter output blk_cnt is enabled by defining AES_ROUND_SCHED_PERF_EN.
module aes_round_sched
    import aes_sched_pkg::*;
#(
    parameter int unsigned RND_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         dp_issue,
    output logic         dp_final,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    input  logic [127:0] dp_result,
    output logic         ke_issue,
    output logic [127:0] ke_key,
    output logic [7:0]   ke_rcon,
    input  logic [127:0] ke_result
`ifdef AES_ROUND_SCHED_PERF_EN
    ,
    output logic [31:0]  blk_cnt
`endif
);

    localparam logic [3:0] LastRnd  = 4'(NUM_ROUNDS);
    localparam logic [2:0] WaitInit = 3'(RND_LAT - 1);

    sched_state_e st_q, st_d;
    logic [127:0] state_q, key_q;
    // Number of steps issued for this block; 0 while the pre-round key step is in flight.
    logic [3:0]   rnd_q;
    logic [2:0]   wait_q;
    logic         accept, capture, issue;
    logic [7:0]   rcon;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= StIdle;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dp_issue  = 1'b0;
        dp_final  = 1'b0;
        ke_issue  = 1'b0;
        capture   = 1'b0;
        unique case (st_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) st_d = StPrekey;
            end
            StPrekey: begin
                ke_issue = 1'b1;
                st_d     = StWait;
            end
            StIssue: begin
                dp_issue = 1'b1;
                dp_final = (rnd_q == LastRnd - 4'd1);
                ke_issue = (rnd_q < LastRnd - 4'd1);
                st_d     = StWait;
            end
            StWait: begin
                if (wait_q == 3'd0) begin
                    capture = 1'b1;
                    st_d    = (rnd_q == LastRnd) ? StOut : StIssue;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign issue  = (st_q == StPrekey) || (st_q == StIssue);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            wait_q  <= '0;
        end else begin
            if (accept) begin
                state_q <= in_data ^ in_key;
                key_q   <= in_key;
                rnd_q   <= '0;
            end
            if (issue) begin
                wait_q <= WaitInit;
            end else if (st_q == StWait && wait_q != 3'd0) begin
                wait_q <= wait_q - 3'd1;
            end
            if (dp_issue) begin
                rnd_q <= rnd_q + 4'd1;
            end
            if (capture) begin
                if (rnd_q != 4'd0) state_q <= dp_result;
                if (rnd_q < LastRnd) key_q <= ke_result;
            end
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (capture && (rnd_q < LastRnd)),
        .rcon  (rcon)
    );

    assign dp_state = state_q;
    assign dp_key   = key_q;
    assign ke_key   = key_q;
    assign ke_rcon  = rcon;
    assign out_data = out_valid ? state_q : '0;

`ifdef AES_ROUND_SCHED_PERF_EN
    logic [31:0] blk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: models the round datapath and key expansion with RND_LAT latency
// and checks FIPS-197 known-answer ciphertexts, timing, rcon sequence and reset behaviour.
module tb_aes_round_sched;

    parameter int unsigned RND_LAT = 2;
    localparam int unsigned EXP_LAT = 1 + 11 * (RND_LAT + 1);

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk, rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_data, in_key, out_data;
    logic         dp_issue, dp_final, ke_issue;
    logic [127:0] dp_state, dp_key, dp_result, ke_key, ke_result;
    logic [7:0]   ke_rcon;
`ifdef AES_ROUND_SCHED_PERF_EN
    logic [31:0]  blk_cnt;
`endif

    aes_round_sched #(.RND_LAT(RND_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dp_issue  (dp_issue),
        .dp_final  (dp_final),
        .dp_state  (dp_state),
        .dp_key    (dp_key),
        .dp_result (dp_result),
        .ke_issue  (ke_issue),
        .ke_key    (ke_key),
        .ke_rcon   (ke_rcon),
        .ke_result (ke_result)
`ifdef AES_ROUND_SCHED_PERF_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- AES reference pieces ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) r = r ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] p, r;
            p = 8'(i);
            r = 8'h01;
            for (int j = 1; j < 8; j++) begin
                p = gmul(p, p);
                r = gmul(r, p);
            end
            sbox[i] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                        ^ {r[3:0], r[7:4]} ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] x0, x1, x2, x3;
                x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
                b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
                b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
                b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // ---------------- datapath model and monitor ----------------
    int unsigned  dp_age = 0, ke_age = 0;
    logic [127:0] dp_res_q = '0, ke_res_q = '0;
    logic [127:0] dp_state_l = '0, dp_key_l = '0, ke_key_l = '0;
    logic [7:0]   ke_rcon_l = '0;
    int           dp_total = 0, ke_total = 0, final_total = 0, last_final_at = 0, hold_errs = 0;
    logic [7:0]   rcon_log [$];

    // Results are only correct on the exact sampling cycle.
    assign dp_result = (dp_age == RND_LAT) ? dp_res_q : ~dp_res_q;
    assign ke_result = (ke_age == RND_LAT) ? ke_res_q : ~ke_res_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_age <= 0;
            ke_age <= 0;
        end else begin
            if (dp_issue) begin
                dp_age     <= 1;
                dp_res_q   <= aes_round(dp_state, dp_key, dp_final);
                dp_state_l <= dp_state;
                dp_key_l   <= dp_key;
                dp_total   <= dp_total + 1;
                if (dp_final) begin
                    final_total   <= final_total + 1;
                    last_final_at <= dp_total + 1;
                end
            end else if (dp_age != 0 && dp_age < 100) begin
                dp_age <= dp_age + 1;
            end
            if (ke_issue) begin
                ke_age    <= 1;
                ke_res_q  <= key_step(ke_key, ke_rcon);
                ke_key_l  <= ke_key;
                ke_rcon_l <= ke_rcon;
                ke_total  <= ke_total + 1;
                rcon_log.push_back(ke_rcon);
            end else if (ke_age != 0 && ke_age < 100) begin
                ke_age <= ke_age + 1;
            end
            if (dp_age >= 1 && dp_age <= RND_LAT &&
                (dp_state !== dp_state_l || dp_key !== dp_key_l))
                hold_errs <= hold_errs + 1;
            if (ke_age >= 1 && ke_age <= RND_LAT &&
                (ke_key !== ke_key_l || ke_rcon !== ke_rcon_l))
                hold_errs <= hold_errs + 1;
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] exp_rcon [10];
    int         blocks_done = 0;

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        check_eq({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check_eq({tag, "_out_data"}, out_data, 128'd0);
        check_eq({tag, "_dp_issue"}, 128'({dp_issue, dp_final, ke_issue}), 128'd0);
        check_eq({tag, "_dp_state"}, dp_state, 128'd0);
        check_eq({tag, "_dp_key"}, dp_key, 128'd0);
        check_eq({tag, "_ke_key"}, ke_key, 128'd0);
        check_eq({tag, "_ke_rcon"}, 128'(ke_rcon), 128'd0);
`ifdef AES_ROUND_SCHED_PERF_EN
        check_eq({tag, "_blk_cnt"}, 128'(blk_cnt), 128'd0);
`endif
    endtask

    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct, input int hold);
        int n;
        int rc0, dp0, ke0, fin0, herr0;
        logic [7:0] got_rc;
        rc0 = rcon_log.size(); dp0 = dp_total; ke0 = ke_total;
        fin0 = final_total; herr0 = hold_errs;
        in_key = key; in_data = pt; in_valid = 1'b1; n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check_eq("accept_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        check_eq("out_latency", 128'(n), 128'(EXP_LAT));
        check_eq("out_data", out_data, ct);
        check_eq("ke_issue_count", 128'(ke_total - ke0), 128'd10);
        check_eq("dp_issue_count", 128'(dp_total - dp0), 128'd10);
        check_eq("dp_final_count", 128'(final_total - fin0), 128'd1);
        check_eq("dp_final_round", 128'(last_final_at - dp0), 128'd10);
        check_eq("operand_hold", 128'(hold_errs - herr0), 128'd0);
        for (int i = 0; i < 10; i++) begin
            got_rc = (rc0 + i < rcon_log.size()) ? rcon_log[rc0 + i] : 8'h00;
            check_eq($sformatf("rcon_%0d", i), 128'(got_rc), 128'(exp_rcon[i]));
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_out_valid", 128'(out_valid), 128'd1);
            check_eq("hold_out_data", out_data, ct);
            check_eq("hold_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        blocks_done++;
        check_eq("post_out_valid", 128'(out_valid), 128'd0);
        check_eq("post_in_ready", 128'(in_ready), 128'd1);
    endtask

    initial begin
        int n;
        int dp0;
        exp_rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("after_reset");

        // FIPS-197 C.1 with a 5-cycle output stall.
        run_block(KEY_C1, PT_C1, CT_C1, 5);

        // Abort a block during round 5.
        in_key = KEY_C1; in_data = PT_C1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dp0 = dp_total; n = 0;
        while (dp_total - dp0 < 5 && n < 300) begin @(posedge clk); #1; n++; end
        check_eq("abort_in_round5", 128'(dp_total - dp0), 128'd5);
        #2 rst_n = 1'b0;
        #1 check_idle("mid_reset");
        blocks_done = 0;
        @(posedge clk); #1;
        check_idle("mid_reset_edge");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back blocks after the abort.
        run_block(KEY_C1, PT_C1, CT_C1, 0);
        run_block(KEY_B, PT_B, CT_B, 0);
        run_block(KEY_C1, PT_C1, CT_C1, 0);
`ifdef AES_ROUND_SCHED_PERF_EN
        check_eq("blk_cnt", 128'(blk_cnt), 128'(blocks_done));
        check_eq("blk_cnt_three", 128'(blk_cnt), 128'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
